// File: rtl/neuron_input_collector.sv
// Collects zero2one_t samples from a valid/ready stream into N-wide vectors for neuron_run.
// Short frames are padded with the minimum value; over-long frames are cut at N and flagged.

package zero2one_pkg;
   typedef logic [15:0] zero2one_t;   // unsigned Q1.15, 16'h8000 = 1.0
endpackage

`ifndef ZERO2ONE_MIN
`define ZERO2ONE_MIN 16'h0000
`endif

// state   | meaning
// --------+---------------------------------------------------------------
// FILL    | accepting samples into the fill buffer at index idx
// PENDING | fill buffer holds a complete vector waiting for the output slot
module neuron_input_collector
   import zero2one_pkg::*;
#(
   parameter int N = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  zero2one_t                in_data,
   input  logic                     in_valid,
   input  logic                     in_last,
   output logic                     in_ready,
   output zero2one_t [N-1:0]        vec_out,
   output logic                     vec_valid,
   input  logic                     vec_ready,
   output logic [$clog2(N+1)-1:0]   fill_count,
   output logic                     framing_error,
   input  logic                     clr_error
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(N+1);

   typedef enum logic {FILL, PENDING} state_t;

   state_t            state;
   logic [IW-1:0]     idx;
   zero2one_t [N-1:0] fill;
   zero2one_t [N-1:0] completed;
   logic              accept;
   logic              last_slot;
   logic              complete;
   logic              slot_free;
   logic              load_direct;
   logic              load_pending;

   assign in_ready     = (state == FILL) && !rst;
   assign accept       = in_valid && in_ready;
   assign last_slot    = (idx == IW'(N-1));
   assign complete     = last_slot || in_last;
   assign slot_free    = !vec_valid || vec_ready;
   assign load_direct  = accept && complete && slot_free;
   assign load_pending = (state == PENDING) && vec_ready;
   assign fill_count   = (state == PENDING) ? CW'(N) : CW'(idx);

   // Vector as it would look if the current sample closes the frame.
   always_comb begin
      completed = fill;
      for (int i = 0; i < N; i++) begin
         if (i > int'(idx))
            completed[i] = `ZERO2ONE_MIN;
         else if (i == int'(idx))
            completed[i] = in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= FILL;
         idx           <= '0;
         fill          <= {N{`ZERO2ONE_MIN}};
         vec_out       <= {N{`ZERO2ONE_MIN}};
         vec_valid     <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  if (complete) begin
                     idx <= '0;
                     if (slot_free)
                        vec_out <= completed;
                     else begin
                        fill  <= completed;
                        state <= PENDING;
                     end
                  end else begin
                     fill[idx] <= in_data;
                     idx       <= idx + IW'(1);
                  end
               end
            end
            PENDING: begin
               if (vec_ready) begin
                  vec_out <= fill;
                  state   <= FILL;
               end
            end
            default: state <= FILL;
         endcase

         if (load_direct || load_pending)
            vec_valid <= 1'b1;
         else if (vec_ready)
            vec_valid <= 1'b0;

         if (clr_error)
            framing_error <= 1'b0;
         else if (accept && last_slot && !in_last)
            framing_error <= 1'b1;
      end
   end

endmodule

// File: doc/neuron_input_collector.md
# neuron_input_collector

Upstream stage of `neuron_run`: accepts `zero2one_t` activation samples one at a time over a valid/ready stream and assembles them into the N-wide `in [N-1:0]` vector that `neuron_run` consumes. The assembled vector is held stable in an output register under a valid/ready handshake while the next vector fills behind it. This gives back-to-back throughput of one vector per N accepted samples. Short frames, marked by `in_last`, are zero-padded. Over-long frames are cut at N and flagged.

## Interface

Parameters:
- `N`, default 16: vector length; must match the downstream `neuron_run` N; N ≥ 2.

Ports:
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `in_data`  input  `zero2one_t`: incoming sample.
- `in_valid`  input  1: `in_data` / `in_last` valid.
- `in_last`  input  1: sample is the final one of its frame.
- `in_ready`  output  1: collector can accept a sample this cycle.
- `vec_out`  output  `zero2one_t [N-1:0]`: assembled vector; index 0 = first sample of frame.
- `vec_valid`  output  1: `vec_out` holds a complete vector.
- `vec_ready`  input  1: consumer takes `vec_out` this cycle.
- `fill_count`  output  $clog2(N+1): samples held in the fill buffer for the current frame.
- `framing_error`  output  1: sticky; a frame reached N samples without `in_last`.
- `clr_error`  input  1: synchronous clear of `framing_error`.

## Operation

- Storage:
  - Fill buffer: N entries.
  - Write index `idx`: 0..N-1.
  - Output register `vec_out`.
  - State: FILL or PENDING.
- Accept = `in_valid && in_ready`. `in_ready = (state == FILL) && !rst`, combinational.
- On accept in FILL, `in_data` is written to `fill[idx]`. Then:
  - Frame not complete (`idx < N-1` and `!in_last`): `idx` increments.
  - Frame complete (`idx == N-1` or `in_last`): the completed vector is the fill contents with this sample, and with entries idx+1..N-1 set to `` `zero2one_min``. `idx` returns to 0.
    - Output slot free (`!vec_valid || vec_ready`): the completed vector loads into `vec_out` on this edge, `vec_valid` sets, and state stays FILL.
    - Output slot busy: the completed vector stays in the fill buffer and state goes to PENDING.
- PENDING:
  - `in_ready` = 0.
  - On the first edge with `vec_ready` high, the fill buffer moves to `vec_out`, `vec_valid` stays 1, and state returns to FILL.
- `vec_valid` clears on an edge with `vec_ready` high when no new vector loads on that edge.
- `vec_out` changes only on the edge that loads a new vector. It is stable whenever `vec_valid && !vec_ready`.
- `framing_error`:
  - Sets on accept with `idx == N-1 && !in_last`. That vector is still delivered, cut at N, and the next sample starts a new frame.
  - `clr_error` takes priority over a same-cycle set.
- `fill_count` = `idx` in FILL; N in PENDING.
- `in_last` with `idx == N-1` is the normal full frame: no padding, no error.
- No arithmetic on samples. Padding value is exactly `` `zero2one_min``.

## Timing

- Reset values, asserted asynchronously:
  - `vec_valid` 0, `vec_out` all `` `zero2one_min``.
  - `idx` 0, `fill_count` 0, state FILL, `framing_error` 0.
  - `in_ready` 0 while `rst` is high, 1 from the first cycle after release.
- Latency: a final sample accepted at edge t gives `vec_valid` = 1 in the cycle after t, when the slot is free.
- Throughput: with `vec_ready` tied 1, the collector accepts a sample every cycle with no bubbles, giving one vector per N cycles.
- PENDING costs no lost cycle: `in_ready` returns the cycle after the draining edge.
- Simultaneous final-sample accept and `vec_ready`: the old vector is consumed and the new one loads on the same edge, so `vec_valid` stays 1.
- Reset mid-frame or in PENDING: all partial or pending data is discarded, and no vector is emitted for it.
- `in_valid` may drop mid-frame for any number of cycles; `idx` holds.

## Test plan

Use N = 4 for all scenarios.

- **Full frame, consumer ready.** Send 0.1, 0.2, 0.3, 0.4 on consecutive cycles, `in_last` on the 4th. Required: `vec_valid` 1 in the following cycle, `vec_out` = {0.1, 0.2, 0.3, 0.4}, `framing_error` 0.
- **Short frame.** Send 0.5, 0.6 with `in_last` on 0.6. Required: `vec_out` = {0.5, 0.6, min, min}, then the next frame starts at index 0.
- **Backpressure.** Hold `vec_ready` = 0 and stream two full frames. Required:
  - First vector held stable.
  - After the 8th sample, state is PENDING, `in_ready` = 0 and `fill_count` = 4.
  - Pulsing `vec_ready` for 1 cycle shows the second vector on the next cycle, with `in_ready` back to 1.
- **Overlength.** Send 5 samples, `in_last` only on the 5th. Required:
  - The vector of the first 4 is delivered.
  - `framing_error` sets on the 4th accept.
  - The 5th sample yields {s5, min, min, min}.
  - `clr_error` clears `framing_error`.
- **Streaming.** Hold `vec_ready` = 1 and `in_valid` = 1 for 16 cycles. Required: `in_ready` never drops, and exactly 4 vectors come out, each valid for one cycle.
- **Reset mid-frame.** Assert `rst` after 2 accepted samples. Required: outputs go to reset values immediately, and no vector is emitted for the partial data.
